// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-way memory arbiter.
package mem_arb_pkg;

    typedef logic [1:0] owner_t;
    localparam owner_t OWN_DBG = 2'd0;
    localparam owner_t OWN_DAT = 2'd1;
    localparam owner_t OWN_INS = 2'd2;

    typedef logic arb_state_t;
    localparam arb_state_t ARB    = 1'b0;
    localparam arb_state_t LOCKED = 1'b1;

    localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_arb_resp_pipe.sv
// Tracks the owner of every read in flight and raises the matching rvalid
// when its data comes back from memory.
module mem_arb_resp_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic [1:0] i_owner,
    output logic       o_dbg_rvalid,
    output logic       o_dat_rvalid,
    output logic       o_ins_rvalid
);

    logic [MEM_LATENCY-1:0] vld_q;
    owner_t                 own_q [MEM_LATENCY];
    logic                   tail_vld;
    owner_t                 tail_own;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_q <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                own_q[i] <= OWN_DBG;
            end
        end else begin
            vld_q[0] <= i_push;
            own_q[0] <= i_owner;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                own_q[i] <= own_q[i-1];
            end
        end
    end

    // The reset gate keeps a read issued just before reset from leaking out.
    assign tail_vld = vld_q[MEM_LATENCY-1] && !i_rst;
    assign tail_own = own_q[MEM_LATENCY-1];

    assign o_dbg_rvalid = tail_vld && (tail_own == OWN_DBG);
    assign o_dat_rvalid = tail_vld && (tail_own == OWN_DAT);
    assign o_ins_rvalid = tail_vld && (tail_own == OWN_INS);

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port word memory between debug, core data and fetch.
// state  | meaning
// ARB    | debug has priority, data/fetch round-robin
// LOCKED | debug holds the bus; only debug may be granted while lock stays high
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 10,
    parameter int DW          = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_dbg_req,
    input  logic          i_dbg_we,
    input  logic          i_dbg_lock,
    input  logic [AW-1:0] i_dbg_addr,
    input  logic [DW-1:0] i_dbg_wdata,
    output logic          o_dbg_gnt,
    output logic          o_dbg_rvalid,
    output logic [DW-1:0] o_dbg_rdata,
    input  logic          i_dat_req,
    input  logic          i_dat_we,
    input  logic [AW-1:0] i_dat_addr,
    input  logic [DW-1:0] i_dat_wdata,
    input  logic [3:0]    i_dat_be,
    output logic          o_dat_gnt,
    output logic          o_dat_rvalid,
    output logic [DW-1:0] o_dat_rdata,
    input  logic          i_ins_req,
    input  logic [AW-1:0] i_ins_addr,
    output logic          o_ins_gnt,
    output logic          o_ins_rvalid,
    output logic [DW-1:0] o_ins_rdata,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic [3:0]    o_mem_be,
    input  logic [DW-1:0] i_mem_rdata
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       last_srv_q;
    logic       locked;
    logic       gnt_dbg;
    logic       gnt_dat;
    logic       gnt_ins;
    owner_t     push_own;

    // Lock release is seen combinationally so arbitration resumes that cycle.
    assign locked = (state_q == LOCKED) && i_dbg_lock;

    always_comb begin
        gnt_dbg = 1'b0;
        gnt_dat = 1'b0;
        gnt_ins = 1'b0;
        if (!i_rst) begin
            if (i_dbg_req) begin
                gnt_dbg = 1'b1;
            end else if (!locked) begin
                if (i_dat_req && (!i_ins_req || last_srv_q)) begin
                    gnt_dat = 1'b1;
                end else if (i_ins_req) begin
                    gnt_ins = 1'b1;
                end
            end
        end
    end

    assign state_d = (locked || (gnt_dbg && i_dbg_lock)) ? LOCKED : ARB;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ARB;
            last_srv_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (gnt_dat) begin
                last_srv_q <= 1'b0;
            end else if (gnt_ins) begin
                last_srv_q <= 1'b1;
            end
        end
    end

    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = i_ins_addr;
        o_mem_wdata = i_dat_wdata;
        o_mem_be    = BE_FULL;
        push_own    = OWN_INS;
        if (gnt_dbg) begin
            o_mem_we    = i_dbg_we;
            o_mem_addr  = i_dbg_addr;
            o_mem_wdata = i_dbg_wdata;
            push_own    = OWN_DBG;
        end else if (gnt_dat) begin
            o_mem_we    = i_dat_we;
            o_mem_addr  = i_dat_addr;
            o_mem_be    = i_dat_be;
            push_own    = OWN_DAT;
        end
    end

    assign o_mem_en  = gnt_dbg || gnt_dat || gnt_ins;
    assign o_dbg_gnt = gnt_dbg;
    assign o_dat_gnt = gnt_dat;
    assign o_ins_gnt = gnt_ins;

    mem_arb_resp_pipe #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_resp_pipe (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (o_mem_en && !o_mem_we),
        .i_owner      (push_own),
        .o_dbg_rvalid (o_dbg_rvalid),
        .o_dat_rvalid (o_dat_rvalid),
        .o_ins_rvalid (o_ins_rvalid)
    );

    assign o_dbg_rdata = i_mem_rdata;
    assign o_dat_rdata = i_mem_rdata;
    assign o_ins_rdata = i_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Drives four arbiters (memory latency 1..4) with the same directed stimulus
// and scores grants, memory commands and steered read responses.
module tb_mem_arbiter;

    typedef struct packed {
        logic [1:0]  own;
        logic [31:0] data;
        logic [31:0] issue;
    } exp_t;

    logic clk;
    logic rst;
    logic mem_clr;
    logic [31:0] cyc;

    logic        dbg_req, dbg_we, dbg_lock;
    logic [9:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dat_req, dat_we;
    logic [9:0]  dat_addr;
    logic [31:0] dat_wdata;
    logic [3:0]  dat_be;
    logic        ins_req;
    logic [9:0]  ins_addr;

    logic [3:0]  dbg_gnt, dat_gnt, ins_gnt;
    logic [3:0]  dbg_rv, dat_rv, ins_rv;
    logic [31:0] dbg_rdata [4];
    logic [31:0] dat_rdata [4];
    logic [31:0] ins_rdata [4];
    logic [3:0]  mem_en, mem_we;
    logic [9:0]  mem_addr  [4];
    logic [31:0] mem_wdata [4];
    logic [3:0]  mem_be    [4];
    logic [31:0] mem_rdata [4];

    int total;
    int bad;
    exp_t exp_q[$];
    int head [4];
    logic [31:0] ref_mem [1024];

    function automatic logic [31:0] init_word(int i);
        return (i == 16) ? 32'h2402_0030 : (32'h1000_0000 + i * 32'h0001_0003);
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_lat
        localparam int LAT = g + 1;
        logic [31:0]   mem [1024];
        logic [1023:0] wr_map;
        logic [31:0]   rd_pipe [LAT];
        logic [31:0]   cur;

        assign cur = wr_map[mem_addr[g]] ? mem[mem_addr[g]] : init_word(int'(mem_addr[g]));

        always @(posedge clk) begin
            if (mem_clr) begin
                wr_map <= '0;
            end else if (mem_en[g] && mem_we[g]) begin
                for (int b = 0; b < 4; b++) begin
                    mem[mem_addr[g]][8*b +: 8] <= mem_be[g][b] ? mem_wdata[g][8*b +: 8] : cur[8*b +: 8];
                end
                wr_map[mem_addr[g]] <= 1'b1;
            end
            rd_pipe[0] <= cur;
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
        assign mem_rdata[g] = rd_pipe[LAT-1];

        mem_arbiter #(.AW(10), .DW(32), .MEM_LATENCY(LAT)) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_dbg_req    (dbg_req),
            .i_dbg_we     (dbg_we),
            .i_dbg_lock   (dbg_lock),
            .i_dbg_addr   (dbg_addr),
            .i_dbg_wdata  (dbg_wdata),
            .o_dbg_gnt    (dbg_gnt[g]),
            .o_dbg_rvalid (dbg_rv[g]),
            .o_dbg_rdata  (dbg_rdata[g]),
            .i_dat_req    (dat_req),
            .i_dat_we     (dat_we),
            .i_dat_addr   (dat_addr),
            .i_dat_wdata  (dat_wdata),
            .i_dat_be     (dat_be),
            .o_dat_gnt    (dat_gnt[g]),
            .o_dat_rvalid (dat_rv[g]),
            .o_dat_rdata  (dat_rdata[g]),
            .i_ins_req    (ins_req),
            .i_ins_addr   (ins_addr),
            .o_ins_gnt    (ins_gnt[g]),
            .o_ins_rvalid (ins_rv[g]),
            .o_ins_rdata  (ins_rdata[g]),
            .o_mem_en     (mem_en[g]),
            .o_mem_we     (mem_we[g]),
            .o_mem_addr   (mem_addr[g]),
            .o_mem_wdata  (mem_wdata[g]),
            .o_mem_be     (mem_be[g]),
            .i_mem_rdata  (mem_rdata[g])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic push_rd(input logic [1:0] own, input logic [9:0] a);
        exp_q.push_back('{own: own, data: ref_mem[a], issue: cyc});
    endtask

    task automatic ref_write(input logic [9:0] a, input logic [31:0] wd, input logic [3:0] be);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    // One clock of stimulus; eg = expected {dbg, dat, ins} grants.
    task automatic cycle(input logic [2:0] eg);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("gnt_lat%0d", k + 1), {61'd0, dbg_gnt[k], dat_gnt[k], ins_gnt[k]}, {61'd0, eg});
        end
        chk("mem_en", {63'd0, mem_en[0]}, {63'd0, |eg});
        if (eg == 3'b000) chk("mem_we_idle", {63'd0, mem_we[0]}, 64'd0);
        if (eg[2]) begin
            chk("dbg_addr", {54'd0, mem_addr[0]}, {54'd0, dbg_addr});
            chk("dbg_we", {63'd0, mem_we[0]}, {63'd0, dbg_we});
            if (dbg_we) begin
                chk("dbg_wdata", {32'd0, mem_wdata[0]}, {32'd0, dbg_wdata});
                chk("dbg_be", {60'd0, mem_be[0]}, 64'hF);
                ref_write(dbg_addr, dbg_wdata, 4'hF);
            end else begin
                push_rd(2'd0, dbg_addr);
            end
        end else if (eg[1]) begin
            chk("dat_addr", {54'd0, mem_addr[0]}, {54'd0, dat_addr});
            chk("dat_we", {63'd0, mem_we[0]}, {63'd0, dat_we});
            if (dat_we) begin
                chk("dat_wdata", {32'd0, mem_wdata[0]}, {32'd0, dat_wdata});
                chk("dat_be", {60'd0, mem_be[0]}, {60'd0, dat_be});
                ref_write(dat_addr, dat_wdata, dat_be);
            end else begin
                push_rd(2'd1, dat_addr);
            end
        end else if (eg[0]) begin
            chk("ins_addr", {54'd0, mem_addr[0]}, {54'd0, ins_addr});
            chk("ins_we", {63'd0, mem_we[0]}, 64'd0);
            chk("ins_be", {60'd0, mem_be[0]}, 64'hF);
            push_rd(2'd2, ins_addr);
        end
        // Reads still in flight when reset is applied must never come back.
        if (rst) begin
            for (int k = 0; k < 4; k++) head[k] = exp_q.size();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;
        dat_req = 0; dat_we = 0; dat_addr = '0; dat_wdata = '0; dat_be = 4'hF;
        ins_req = 0; ins_addr = '0;
    endtask

    task automatic idle(input int n);
        clear_reqs();
        for (int i = 0; i < n; i++) cycle(3'b000);
    endtask

    // Response monitor: pops the scoreboard whenever any rvalid is seen.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            int nv;
            logic [1:0]  own;
            logic [31:0] data;
            exp_t e;
            nv = int'(dbg_rv[k]) + int'(dat_rv[k]) + int'(ins_rv[k]);
            own  = dat_rv[k] ? 2'd1 : (ins_rv[k] ? 2'd2 : 2'd0);
            data = dat_rv[k] ? dat_rdata[k] : (ins_rv[k] ? ins_rdata[k] : dbg_rdata[k]);
            if (nv > 1) begin
                total++; bad++;
                $display("FAIL rvalid_multi lat%0d cycle %0d: %0d rvalids want 1", k + 1, cyc, nv);
            end else if (nv == 1) begin
                if (head[k] >= exp_q.size()) begin
                    total++; bad++;
                    $display("FAIL rvalid_unexp lat%0d cycle %0d: owner %0d rvalid, want none", k + 1, cyc, own);
                end else begin
                    e = exp_q[head[k]];
                    head[k]++;
                    chk($sformatf("rsp_owner_lat%0d", k + 1), {62'd0, own}, {62'd0, e.own});
                    chk($sformatf("rsp_data_lat%0d", k + 1), {32'd0, data}, {32'd0, e.data});
                    chk($sformatf("rsp_delay_lat%0d", k + 1), {32'd0, cyc - e.issue}, 64'(k + 1));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad = 0;
        cyc = 0;
        for (int k = 0; k < 4; k++) head[k] = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        clear_reqs();
        rst = 1;
        mem_clr = 1;

        // Reset: requests present but nothing may be granted.
        dat_req = 1; ins_req = 1;
        cycle(3'b000);
        mem_clr = 0;
        cycle(3'b000);
        rst = 0;
        idle(1);

        // Single fetch from 0x010.
        ins_req = 1; ins_addr = 10'h010;
        cycle(3'b001);
        idle(5);

        // Contention: dat and ins alternate, dat first.
        for (int i = 0; i < 6; i++) begin
            dat_req = 1; dat_addr = 10'h020 + 10'((i + 1) / 2);
            ins_req = 1; ins_addr = 10'h030 + 10'(i / 2);
            cycle((i % 2 == 0) ? 3'b010 : 3'b001);
        end
        idle(5);

        // Debug burst under lock, including an idle locked cycle.
        dat_req = 1; dat_addr = 10'h040;
        ins_req = 1; ins_addr = 10'h050;
        dbg_req = 1; dbg_we = 1; dbg_lock = 1; dbg_addr = 10'h141; dbg_wdata = 32'h30;
        cycle(3'b100);
        dbg_req = 0; dbg_we = 0;
        cycle(3'b000);
        dbg_req = 1; dbg_we = 1; dbg_addr = 10'h142; dbg_wdata = 32'h31;
        cycle(3'b100);
        dbg_addr = 10'h143; dbg_wdata = 32'h32;
        cycle(3'b100);
        dbg_req = 0; dbg_we = 0; dbg_lock = 0;
        cycle(3'b010);
        dat_req = 0;
        cycle(3'b001);
        clear_reqs();
        dbg_req = 1; dbg_addr = 10'h141;
        cycle(3'b100);
        idle(5);

        // Byte write then read-back of the merged word.
        dat_req = 1; dat_we = 1; dat_be = 4'b0010; dat_addr = 10'h140; dat_wdata = 32'hAABB_CCDD;
        cycle(3'b010);
        dat_we = 0; dat_be = 4'hF;
        cycle(3'b010);
        idle(5);

        // Reset with reads in flight; dat was served last before reset.
        ins_req = 1; ins_addr = 10'h030;
        cycle(3'b001);
        clear_reqs();
        dat_req = 1; dat_addr = 10'h020;
        cycle(3'b010);
        rst = 1; ins_req = 1; ins_addr = 10'h031;
        cycle(3'b000);
        rst = 0;
        idle(4);
        dat_req = 1; dat_addr = 10'h022;
        ins_req = 1; ins_addr = 10'h033;
        cycle(3'b010);
        dat_req = 0;
        cycle(3'b001);
        idle(6);

        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drained_lat%0d", k + 1), 64'(head[k]), 64'(exp_q.size()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port unified SoC word memory between three requesters: debug/loader port, core data port and core instruction-fetch port.
- Sits in top between the core and the memory instance.
- Fixed priority for the debug port. Round-robin between data and fetch.
- Pipelined, with one memory command per cycle. Read responses are steered back to their owners after the memory read latency.

Parameters:
- AW, 10, word-address width (1024 x 32-bit words).
- DW, 32, data width.
- MEM_LATENCY, 1, cycles from command issue to valid i_mem_rdata (legal range 1..4).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous reset, active-high.
- i_dbg_req  in  1  debug access request.
- i_dbg_we  in  1  debug write enable.
- i_dbg_lock  in  1  debug bus lock (burst load).
- i_dbg_addr  in  AW  debug word address.
- i_dbg_wdata  in  DW  debug write data.
- o_dbg_gnt  out  1  debug command accepted this cycle.
- o_dbg_rvalid  out  1  debug read data valid.
- o_dbg_rdata  out  DW  debug read data.
- i_dat_req, i_dat_we, i_dat_addr[AW], i_dat_wdata[DW], i_dat_be[4]  in  core data port.
- o_dat_gnt, o_dat_rvalid, o_dat_rdata[DW]  out  core data port.
- i_ins_req, i_ins_addr[AW]  in  fetch port (read only).
- o_ins_gnt, o_ins_rvalid, o_ins_rdata[DW]  out  fetch port.
- o_mem_en, o_mem_we, o_mem_addr[AW], o_mem_wdata[DW], o_mem_be[4]  out  memory command.
- i_mem_rdata  in  DW  memory read data.

Behaviour:
- Handshake:
  - Requester holds req and its fields stable until gnt.
  - gnt is combinational in the same cycle.
  - A command is transferred when req && gnt.
  - At most one gnt is high per cycle.
- Memory command:
  - o_mem_* is a combinational mux of the granted requester.
  - o_mem_en equals the OR of all gnt.
  - Debug writes drive be=4'hF; fetch drives we=0 and be=4'hF.
  - When no grant: o_mem_en=0, o_mem_we=0, other fields don't-care.
- Arbitration in state ARB:
  - dbg_req has top priority.
  - Otherwise, if only one of dat/ins requests, it wins.
  - If both request, the one not served last wins.
  - Register last_srv (0=dat, 1=ins) updates only on a dat or ins grant. A dbg grant leaves it unchanged.
- FSM, states ARB and LOCKED:
  - ARB -> LOCKED when dbg is granted and i_dbg_lock=1.
  - In LOCKED, only dbg can be granted; dat/ins gnt stay 0 even if dbg_req=0.
  - LOCKED -> ARB on the first cycle where i_dbg_lock=0 is sampled. Normal arbitration applies in that same cycle.
- Response steering:
  - A MEM_LATENCY-deep shift register carries {valid, owner[1:0]} for each read command.
  - Writes do not enter it.
  - At the tail, the matching o_X_rvalid pulses for 1 cycle and o_X_rdata = i_mem_rdata.
  - rdata is don't-care when rvalid=0.
  - Back-to-back reads from different owners return in issue order, one per cycle.
- Simultaneous events: a new grant and the return of an earlier response in the same cycle are independent and both happen.
- Reset:
  - Synchronous. All gnt/rvalid and o_mem_en/o_mem_we are forced 0 while i_rst=1.
  - State resets to ARB, last_srv to 1 (so dat wins the first tie), and the shift register clears.
  - Reads in flight at reset never produce rvalid.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef owner_t, 2 bits: OWN_DBG=0, OWN_DAT=1, OWN_INS=2.
  - typedef arb_state_t: ARB, LOCKED.
  - constant BE_FULL=4'hF.
- Sub-module mem_arb_resp_pipe (parameter MEM_LATENCY) holds the owner/valid shift register and the rvalid decode.
- The arbiter and mux live in mem_arbiter.

Test Plan:
1. Single fetch: ins_req at addr 0x010, mem[0x010]=0x2402_0030 -> ins_gnt same cycle; ins_rvalid exactly MEM_LATENCY cycles later with rdata 0x2402_0030; no other rvalid.
2. Contention: dat and ins request continuously for 6 cycles after reset -> grants alternate dat, ins, dat, ins, dat, ins; every rvalid matches its owner's address data in issue order.
3. Debug priority and lock: dbg writes 0x30 to 0x141 with lock=1 for 3 words while dat/ins request -> dat/ins gnt=0 until the cycle lock drops, including idle dbg cycles; mem[0x141]=0x30; then round-robin resumes with last_srv unchanged.
4. Byte write: dat_we=1, be=4'b0010, wdata=0xAABBCCDD to 0x140 -> o_mem_be=0010, o_mem_we=1; no rvalid on any port.
5. Reset mid-operation: 2 reads in flight (MEM_LATENCY=2), i_rst asserted 1 cycle -> no rvalid on any port in the following 4 cycles; first tie after reset is granted to dat.
6. Latency sweep: repeat scenario 2 with MEM_LATENCY=1,3,4 -> rvalid offset equals MEM_LATENCY; one rvalid per read; no drops.
